// File: rtl/pulse_sched.sv
// Multi-channel timed pulse scheduler: per-channel {time, cmd} FIFOs released when qclk reaches the head timestamp.
// Build option: define PULSE_SCHED_LATE_DROP_EN to discard late heads silently instead of issuing them.

module pulse_sched_chan #(
    parameter int DATA_WIDTH  = 32,
    parameter int PULSE_WIDTH = 72,
    parameter int DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  qclk,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_time,
    input  logic [PULSE_WIDTH-1:0] push_cmd,
    output logic                   full,
    output logic                   empty,
    output logic [PULSE_WIDTH-1:0] cmd,
    output logic                   cstrobe,
    output logic                   late_err
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]  time_mem [DEPTH];
    logic [PULSE_WIDTH-1:0] cmd_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]  head_time, diff;
    logic [PULSE_WIDTH-1:0] head_cmd;
    logic                   match, late, pop, issue;

    // Extra pointer MSB separates full from empty when the index bits agree.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign head_time = time_mem[rd_ptr[AW-1:0]];
    assign head_cmd  = cmd_mem[rd_ptr[AW-1:0]];

    // Signed modular distance keeps the compare correct across qclk wrap.
    assign diff  = head_time - qclk;
    assign match = !empty && (diff == '0);
    assign late  = !empty && diff[DATA_WIDTH-1];
    assign pop   = match || late;

`ifdef PULSE_SCHED_LATE_DROP_EN
    assign issue = match;
`else
    assign issue = match || late;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            time_mem[wr_ptr[AW-1:0]] <= push_time;
            cmd_mem[wr_ptr[AW-1:0]]  <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cmd      <= '0;
            cstrobe  <= 1'b0;
            late_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cstrobe <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            cstrobe <= issue;
            if (issue)
                cmd <= head_cmd;
            if (late)
                late_err <= 1'b1;
        end
    end
endmodule

module pulse_sched #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int PULSE_WIDTH = 72,
    parameter  int N_CHAN      = 4,
    parameter  int DEPTH       = 8,
    localparam int CHAN_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         qclk,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_time,
    input  logic [PULSE_WIDTH-1:0]        in_cmd,
    input  logic [CHAN_W-1:0]             in_chan,
    output logic [N_CHAN*PULSE_WIDTH-1:0] cmd_out,
    output logic [N_CHAN-1:0]             cstrobe_out,
    output logic [N_CHAN-1:0]             chan_full,
    output logic [N_CHAN-1:0]             chan_empty,
    output logic [N_CHAN-1:0]             late_err
);
    logic [N_CHAN-1:0][PULSE_WIDTH-1:0] cmd_q;
    logic [N_CHAN-1:0]                  push;
    logic                               sel_full;

    // An unmatched (out-of-range) channel reads as full, so it is never accepted.
    always_comb begin
        sel_full = 1'b1;
        for (int c = 0; c < N_CHAN; c++)
            if (in_chan == CHAN_W'(c))
                sel_full = chan_full[c];
        in_ready = !reset && !flush && !sel_full;
    end

    assign cmd_out = cmd_q;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        assign push[c] = in_valid && in_ready && (in_chan == CHAN_W'(c));

        pulse_sched_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .PULSE_WIDTH(PULSE_WIDTH),
            .DEPTH      (DEPTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .qclk     (qclk),
            .flush    (flush),
            .push     (push[c]),
            .push_time(in_time),
            .push_cmd (in_cmd),
            .full     (chan_full[c]),
            .empty    (chan_empty[c]),
            .cmd      (cmd_q[c]),
            .cstrobe  (cstrobe_out[c]),
            .late_err (late_err[c])
        );
    end
endmodule

// File: tb/tb_pulse_sched.sv
// Directed plus randomized bench for pulse_sched against a queue-based scheduling model.
module tb_pulse_sched;
    localparam int N  = 4;
    localparam int PW = 72;
    localparam int DW = 32;
    localparam int D  = 8;
`ifdef PULSE_SCHED_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   qclk = '0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_time = '0;
    logic [PW-1:0]   in_cmd = '0;
    logic [1:0]      in_chan = '0;
    logic [N*PW-1:0] cmd_out;
    logic [N-1:0]    cstrobe_out, chan_full, chan_empty, late_err;

    pulse_sched #(.DATA_WIDTH(DW), .PULSE_WIDTH(PW), .N_CHAN(N), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .qclk(qclk), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
        .in_cmd(in_cmd), .in_chan(in_chan), .cmd_out(cmd_out),
        .cstrobe_out(cstrobe_out), .chan_full(chan_full),
        .chan_empty(chan_empty), .late_err(late_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] t;
        logic [PW-1:0] c;
    } ent_t;

    ent_t                       mq [N][$];
    logic [N-1:0][PW-1:0]       m_cmd = '0;
    logic [N-1:0]               m_strobe = '0;
    logic [N-1:0]               m_late = '0;
    int                         total = 0;
    int                         bad = 0;

    task automatic chk(input string tag, input logic [N*PW-1:0] obs, input logic [N*PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge: scheduling rules applied to per-channel queues.
    task automatic model_step();
        logic          rdy;
        logic [DW-1:0] d;
        rdy = !reset && !flush && (int'(in_chan) < N) && (mq[in_chan].size() < D);
        chk("in_ready", in_ready, rdy);
        if (reset) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            m_cmd = '0; m_strobe = '0; m_late = '0;
        end else if (flush) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            m_strobe = '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                m_strobe[c] = 1'b0;
                if (mq[c].size() > 0) begin
                    d = mq[c][0].t - qclk;
                    if (d == 0) begin
                        m_strobe[c] = 1'b1;
                        m_cmd[c] = mq[c][0].c;
                        void'(mq[c].pop_front());
                    end else if ($signed(d) < 0) begin
                        m_late[c] = 1'b1;
                        if (!DROP) begin
                            m_strobe[c] = 1'b1;
                            m_cmd[c] = mq[c][0].c;
                        end
                        void'(mq[c].pop_front());
                    end
                end
            end
            if (in_valid && rdy) mq[in_chan].push_back('{t: in_time, c: in_cmd});
        end
    endtask

    task automatic tick();
        logic [N-1:0] ef, ee;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            ef[c] = (mq[c].size() == D);
            ee[c] = (mq[c].size() == 0);
        end
        chk("cstrobe_out", cstrobe_out, m_strobe);
        chk("cmd_out", cmd_out, m_cmd);
        chk("chan_full", chan_full, ef);
        chk("chan_empty", chan_empty, ee);
        chk("late_err", late_err, m_late);
    endtask

    task automatic push(input int ch, input logic [DW-1:0] t, input logic [PW-1:0] c);
        in_valid = 1'b1; in_chan = 2'(ch); in_time = t; in_cmd = c;
        tick();
        in_valid = 1'b0;
    endtask

    int cnt;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst empty", chan_empty, 4'hF);
        chk("rst cmd", cmd_out, '0);
        reset = 1'b0;

        // Single entry on ch0 at qclk 100
        qclk = 90;
        push(0, 100, 72'hA5);
        for (int i = 91; i <= 100; i++) begin qclk = i; tick(); end
        chk("t1 strobe", cstrobe_out, 4'b0001);
        chk("t1 cmd", cmd_out[PW-1:0], 72'hA5);
        qclk = 101; tick();
        chk("t1 strobe off", cstrobe_out, 4'b0000);

        // Fill ch2, then drain on consecutive cycles
        qclk = 150;
        for (int i = 0; i < D; i++) push(2, 200 + i, 72'h200 + i);
        chk("t2 full", chan_full[2], 1'b1);
        in_chan = 2; #1;
        chk("t2 rdy ch2", in_ready, 1'b0);
        in_chan = 1; #1;
        chk("t2 rdy ch1", in_ready, 1'b1);
        cnt = 0;
        for (int i = 200; i < 208; i++) begin
            qclk = i; tick();
            cnt += int'(cstrobe_out[2]);
        end
        chk("t2 strobes", cnt, 8);
        chk("t2 empty", chan_empty[2], 1'b1);

        // Late entry on ch1
        qclk = 60;
        push(1, 50, 72'h5A);
        tick();
        chk("t3 late", late_err[1], 1'b1);
        chk("t3 strobe", cstrobe_out[1], !DROP);

        // Same timestamp on ch0 and ch3
        qclk = 290;
        push(0, 300, 72'h111);
        push(3, 300, 72'h333);
        for (int i = 291; i <= 300; i++) begin qclk = i; tick(); end
        chk("t4 strobe", cstrobe_out, 4'b1001);
        chk("t4 cmd0", cmd_out[PW-1:0], 72'h111);
        chk("t4 cmd3", cmd_out[3*PW +: PW], 72'h333);

        // Full ch0 at its match cycle with a concurrent push
        qclk = 390;
        for (int i = 0; i < D; i++) push(0, 400 + i, 72'h400 + i);
        qclk = 400;
        in_valid = 1'b1; in_chan = 0; in_time = 500; in_cmd = 72'h77; #1;
        chk("t5 refused", in_ready, 1'b0);
        tick();
        chk("t5 not full", chan_full[0], 1'b0);
        qclk = 401; #1;
        chk("t5 retry rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 402; i < 410; i++) begin qclk = i; tick(); end

        // Flush, then reset, with entries queued everywhere
        for (int c = 0; c < N; c++) push(c, 1000 + c, 72'hF0 + c);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6 flush empty", chan_empty, 4'hF);
        for (int i = 1000; i < 1005; i++) begin qclk = i; tick(); end
        for (int c = 0; c < N; c++) push(c, 2000 + c, 72'hE0 + c);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6 rst late", late_err, 4'h0);
        chk("t6 rst cmd", cmd_out, '0);
        chk("t6 rst empty", chan_empty, 4'hF);

        // Randomized traffic across the qclk wrap
        qclk = 32'hFFFF_FF00;
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_chan  = 2'($urandom_range(0, N - 1));
            in_time  = qclk + 32'($urandom_range(0, 24)) - 32'd3;
            in_cmd   = {8'($urandom), $urandom, $urandom};
            flush    = ($urandom_range(0, 63) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            tick();
            qclk = qclk + 1;
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
